// File: rtl/noc_pkg.sv
// Shared NoC definitions: default sizes, lock FSM state encoding and a clog2 helper.
package noc_pkg;

  localparam int unsigned NOC_N_REQ   = 4;
  localparam int unsigned NOC_CREDITS = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Ceiling log2, never less than 1 so that derived vectors stay legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after ptr, wrapping.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned N_REQ = NOC_N_REQ
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]        grant
);

  localparam int unsigned PW = clog2(N_REQ);

  // Scan indices ptr+1 .. ptr+N_REQ (mod N_REQ); the first active request wins.
  always_comb begin
    int unsigned   idx;
    logic [PW-1:0] idx_w;
    logic          found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = PW'(idx);
      if (!found && req[idx_w]) begin
        grant[idx_w] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Output port arbiter: round-robin selection of input FIFOs onto one credit-flow-
// controlled link. Define OUTPUT_PORT_ARBITER_LOCK_EN to enable wormhole locking
// (a head flit locks the link to its requester until that requester sends a tail).
module output_port_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned N_REQ   = NOC_N_REQ,
  parameter int unsigned CREDITS = NOC_CREDITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        empty,
  input  logic [N_REQ-1:0]        tail,
  input  logic                    ret,
  output logic [N_REQ-1:0]        read,
  output logic                    val,
  output logic [clog2(N_REQ)-1:0] sel,
  output logic                    credit_err
);

  localparam int unsigned   SW       = clog2(N_REQ);
  localparam int unsigned   CW       = clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [SW-1:0] LAST_RST = SW'(N_REQ - 1);

  logic [CW-1:0]    credit_q, credit_d;
  logic [SW-1:0]    last_q, last_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic             val_q, val_d;
  logic             err_q, err_d;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [SW-1:0]    win_idx;
  logic             send;

`ifdef OUTPUT_PORT_ARBITER_LOCK_EN
  arb_state_e    state_q, state_d;
  logic [SW-1:0] owner_q, owner_d;

  // While a packet is in flight only its owner may request the link.
  always_comb begin
    req = ~empty;
    if (state_q == ST_LOCKED) begin
      req          = '0;
      req[owner_q] = ~empty[owner_q];
    end
  end

  // Lock FSM next state: head flits lock the link, the owner's tail releases it.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (send) begin
      case (state_q)
        ST_IDLE: begin
          if (!tail[win_idx]) begin
            state_d = ST_LOCKED;
            owner_d = win_idx;
          end
        end
        ST_LOCKED: begin
          if (tail[win_idx]) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ^tail;
  assign req         = ~empty;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (last_q),
    .grant (grant)
  );

  // Encode the one-hot grant into a mux index.
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) win_idx = SW'(i);
    end
  end

  // A flit leaves only with a credit in hand; nothing moves while reset is held.
  assign send = rst_n && (credit_q != '0) && (|grant);
  assign read = send ? grant : '0;

  // Credit accounting, pointer update and link-side output staging.
  always_comb begin
    credit_d = credit_q;
    last_d   = last_q;
    sel_d    = sel_q;
    val_d    = send;
    err_d    = err_q;
    if (send) begin
      last_d = win_idx;
      sel_d  = win_idx;
    end
    if (send && !ret) begin
      credit_d = credit_q - CW'(1);
    end else if (ret && !send) begin
      if (credit_q == CRED_MAX) err_d = 1'b1;
      else                      credit_d = credit_q + CW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= CRED_MAX;
      last_q   <= LAST_RST;
      sel_q    <= '0;
      val_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      val_q    <= val_d;
      err_q    <= err_d;
    end
  end

  assign val        = val_q;
  assign sel        = sel_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model.
module tb_output_port_arbiter;

  localparam int N  = 4;
  localparam int CR = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] empty = 4'hF;
  logic [3:0] tail  = 4'h0;
  logic       ret   = 1'b0;
  logic [3:0] read;
  logic       val;
  logic [1:0] sel;
  logic       credit_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  int m_credits;
  int m_last;
  int m_owner;
  bit m_locked;
  bit m_err;
  bit m_val;
  int m_sel;
  int p_win;
  bit p_send;

  always #5 clk = ~clk;

  output_port_arbiter #(
    .N_REQ   (N),
    .CREDITS (CR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .empty      (empty),
    .tail       (tail),
    .ret        (ret),
    .read       (read),
    .val        (val),
    .sel        (sel),
    .credit_err (credit_err)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_credits = CR;
    m_last    = N - 1;
    m_owner   = 0;
    m_locked  = 1'b0;
    m_err     = 1'b0;
    m_val     = 1'b0;
    m_sel     = 0;
  endtask

  // Who would be served right now, given current inputs and model state.
  task automatic model_eval();
    p_win = -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (p_win < 0 && !empty[i] && (!m_locked || i == m_owner)) p_win = i;
    end
    p_send = (m_credits > 0) && (p_win >= 0);
  endtask

  // Apply one clock edge worth of model updates.
  task automatic model_commit();
    m_val = p_send;
    if (p_send) begin
      m_last = p_win;
      m_sel  = p_win;
`ifdef OUTPUT_PORT_ARBITER_LOCK_EN
      if (!m_locked && !tail[p_win]) begin
        m_locked = 1'b1;
        m_owner  = p_win;
      end else if (m_locked && tail[p_win]) begin
        m_locked = 1'b0;
      end
`endif
    end
    if (p_send && !ret) m_credits--;
    else if (ret && !p_send) begin
      if (m_credits == CR) m_err = 1'b1;
      else m_credits++;
    end
  endtask

  // One cycle: drive at negedge, check read, clock, then check registered outputs.
  task automatic step(input logic [3:0] e, input logic [3:0] t, input logic r,
                      output logic [3:0] rd);
    int exp_rd;
    empty = e;
    tail  = t;
    ret   = r;
    #1;
    model_eval();
    exp_rd = p_send ? (1 << p_win) : 0;
    check("read", int'(read), exp_rd);
    rd = read;
    @(posedge clk);
    model_commit();
    @(negedge clk);
    check("val", int'(val), int'(m_val));
    check("sel", int'(sel), m_sel);
    check("credit_err", int'(credit_err), int'(m_err));
  endtask

  // Asynchronous reset asserted mid-cycle, released at the next negedge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_read", int'(read), 0);
    check("rst_val", int'(val), 0);
    check("rst_credit_err", int'(credit_err), 0);
    check("rst_sel", int'(sel), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rd;
    int         sends;

    model_reset();
    @(negedge clk);
    do_reset();

    // Single requester 0 with a tail flit.
    step(4'b1110, 4'b0001, 1'b0, rd);
    check("r026_read", int'(rd), 1);
    check("r026_val", int'(val), 1);
    check("r026_sel", int'(sel), 0);

    // Round robin until credits run out, then one credit returns.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, 4'b1111, 1'b0, rd);
      check("r027_grant", int'(rd), 1 << i);
    end
    step(4'b0000, 4'b1111, 1'b0, rd);
    check("r027_starved", int'(rd), 0);
    step(4'b0000, 4'b1111, 1'b1, rd);
    check("r027_ret_cycle", int'(rd), 0);
    step(4'b0000, 4'b1111, 1'b0, rd);
    check("r027_after_ret", int'(rd), 1);
    step(4'b0000, 4'b1111, 1'b0, rd);
    check("r027_dry_again", int'(rd), 0);

    // Send and ret together at two credits leaves two credits.
    do_reset();
    step(4'b0000, 4'b1111, 1'b0, rd);
    step(4'b0000, 4'b1111, 1'b0, rd);
    step(4'b0000, 4'b1111, 1'b1, rd);
    check("r029_send_with_ret", int'(rd), 4);
    sends = 0;
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, 4'b1111, 1'b0, rd);
      if (rd != 4'b0000) sends++;
    end
    check("r029_credits_kept", sends, 2);

    // Overflowing return at full credits.
    do_reset();
    step(4'b1111, 4'b0000, 1'b1, rd);
    check("r029_err_set", int'(credit_err), 1);
    sends = 0;
    for (int i = 0; i < 6; i++) begin
      step(4'b0000, 4'b1111, 1'b0, rd);
      if (rd != 4'b0000) sends++;
    end
    check("r029_credits_capped", sends, CR);
    check("r029_err_sticky", int'(credit_err), 1);

`ifdef OUTPUT_PORT_ARBITER_LOCK_EN
    // Owner stalls mid-packet; others stay blocked until its tail goes.
    do_reset();
    step(4'b1101, 4'b0000, 1'b0, rd);
    check("r028_head", int'(rd), 2);
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, 4'b0000, 1'b0, rd);
      check("r028_blocked", int'(rd), 0);
    end
    step(4'b0000, 4'b0010, 1'b0, rd);
    check("r028_tail", int'(rd), 2);
    step(4'b0000, 4'b1111, 1'b0, rd);
    check("r028_resume", int'(rd), 4);
`endif

    // Reset in the middle of a packet.
    do_reset();
    step(4'b1111, 4'b0000, 1'b1, rd);
    step(4'b0000, 4'b0000, 1'b0, rd);
    check("r030_head", int'(rd), 1);
    empty = 4'b0000;
    tail  = 4'b0000;
    ret   = 1'b0;
    #1;
`ifdef OUTPUT_PORT_ARBITER_LOCK_EN
    check("r030_pre_read", int'(read), 1);
`else
    check("r030_pre_read", int'(read), 2);
`endif
    check("r030_pre_err", int'(credit_err), 1);
    do_reset();
    step(4'b0000, 4'b1111, 1'b0, rd);
    check("r030_prio0", int'(rd), 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      logic [3:0] e;
      logic [3:0] t;
      logic       r;
      e = 4'($urandom & $urandom);
      t = 4'($urandom);
      r = ($urandom_range(2) == 0);
      if ($urandom_range(63) == 0) do_reset();
      else step(e, t, r, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
